// File: rtl/sopc_2_watchdog_kicker.sv
// Autonomous Avalon-MM master for the SOPC watchdog: starts it, then periodically
// reloads it on application heartbeat, polls status and clears any timeout.
module sopc_2_watchdog_kicker #(
  parameter int KICK_PERIOD = 2500000,
  parameter bit IRQ_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        heartbeat,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  output logic [15:0] kick_count,
  output logic [7:0]  timeout_count,
  output logic        timeout_seen,
  output logic        missed_kick,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    KICK    = 3'd3,
    RD_ADDR = 3'd4,
    RD_CAP  = 3'd5,
    CLEAR   = 3'd6
  } state_t;

  localparam int CW = (KICK_PERIOD > 2) ? $clog2(KICK_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD     = CW'(KICK_PERIOD - 1);
  localparam logic [15:0]   START_WORD = {13'd0, 1'b1, 1'b0, IRQ_EN};

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           hb_q;
  logic [2:0]     address_q;
  logic           chipselect_q;
  logic           write_n_q;
  logic [15:0]    writedata_q;
  logic [15:0]    kick_count_q;
  logic [7:0]     timeout_count_q;
  logic           timeout_seen_q;
  logic           missed_kick_q;
  logic           busy_q;

  // Only the running/timeout status bits matter to the sequencer.
  logic unused_rd;
  assign unused_rd = ^readdata[15:2];

  // Bus protocol: the slave has no waitrequest, so every access is a one-cycle
  // chipselect strobe (write_n=0 write, write_n=1 read); read data is returned
  // by the slave one cycle later while address is held at 0.
  // Bus outputs are registered for the state being entered, so they are valid
  // for exactly the cycle spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      hb_q            <= 1'b0;
      address_q       <= 3'd0;
      chipselect_q    <= 1'b0;
      write_n_q       <= 1'b1;
      writedata_q     <= 16'd0;
      kick_count_q    <= 16'd0;
      timeout_count_q <= 8'd0;
      timeout_seen_q  <= 1'b0;
      missed_kick_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      chipselect_q  <= 1'b0;
      write_n_q     <= 1'b1;
      address_q     <= 3'd0;
      writedata_q   <= 16'd0;
      missed_kick_q <= 1'b0;
      hb_q          <= hb_q | heartbeat;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q      <= START;
            busy_q       <= 1'b1;
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b0;
            address_q    <= 3'd1;
            writedata_q  <= START_WORD;
          end
        end
        START: begin
          cnt_q   <= RELOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (!enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= KICK;
            if (hb_q || heartbeat) begin
              chipselect_q <= 1'b1;
              write_n_q    <= 1'b0;
              address_q    <= 3'd2;
              kick_count_q <= kick_count_q + 16'd1;
            end else begin
              missed_kick_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        KICK: begin
          // Flag is consumed here; a heartbeat in this same cycle re-arms it.
          hb_q         <= heartbeat;
          state_q      <= RD_ADDR;
          chipselect_q <= 1'b1;
        end
        RD_ADDR: begin
          state_q <= RD_CAP;
        end
        RD_CAP: begin
          if (!readdata[1]) begin
            state_q      <= START;
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b0;
            address_q    <= 3'd1;
            writedata_q  <= START_WORD;
          end else if (readdata[0]) begin
            state_q        <= CLEAR;
            chipselect_q   <= 1'b1;
            write_n_q      <= 1'b0;
            timeout_seen_q <= 1'b1;
            if (timeout_count_q != 8'hFF) timeout_count_q <= timeout_count_q + 8'd1;
          end else begin
            cnt_q   <= RELOAD;
            state_q <= WAIT;
          end
        end
        CLEAR: begin
          cnt_q   <= RELOAD;
          state_q <= WAIT;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address       = address_q;
  assign chipselect    = chipselect_q;
  assign write_n       = write_n_q;
  assign writedata     = writedata_q;
  assign kick_count    = kick_count_q;
  assign timeout_count = timeout_count_q;
  assign timeout_seen  = timeout_seen_q;
  assign missed_kick   = missed_kick_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/sopc_2_watchdog_kicker.md
# sopc_2_watchdog_kicker

Avalon-MM master that initialises and services the SOPC watchdog timer slave without CPU involvement. After enable it starts the watchdog, then every KICK_PERIOD cycles reloads it (period write) provided the application heartbeat was seen, polls status, and clears/records any timeout. It sits beside the watchdog in the same clock domain, wired point-to-point to the watchdog's s1 port (address/chipselect/write_n/writedata/readdata).

## Interface
- KICK_PERIOD, 2500000: cycles spent in WAIT between kick sequences; must be ≥2 and less than the watchdog reload period (5,000,000).
- IRQ_EN, 1: value written to control bit 0 (interrupt enable) at start.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run the kick sequencer.
- heartbeat  in  1  single-cycle pulse from the application proving liveness.
- address  out  3  watchdog register index (0 status, 1 control, 2 period_l).
- chipselect  out  1  bus access strobe.
- write_n  out  1  0 = write, 1 = read.
- writedata  out  16  write data.
- readdata  in  16  watchdog read data, registered by the slave (1-cycle latency).
- kick_count  out  16  number of kicks issued, wraps.
- timeout_count  out  8  timeouts observed, saturates at 255.
- timeout_seen  out  1  sticky, set on first observed timeout.
- missed_kick  out  1  one-cycle pulse when a kick is skipped for lack of heartbeat.
- busy  out  1  1 whenever state ≠ IDLE.

## Operation
- States: IDLE, START, WAIT, KICK, RD_ADDR, RD_CAP, CLEAR.
- IDLE: bus idle (chipselect 0, write_n 1, address 0, writedata 0). enable=1 → START.
- START: one write, address 1, writedata 0x0004 | IRQ_EN (START bit 2). Load period counter with KICK_PERIOD-1 → WAIT.
- WAIT: bus idle; counter decrements each cycle; at 0 → KICK. WAIT lasts exactly KICK_PERIOD cycles.
- KICK: if hb_flag=1: write address 2, writedata 0x0000, kick_count+1, clear hb_flag. If hb_flag=0: no bus access, missed_kick=1. Either case → RD_ADDR.
- RD_ADDR: chipselect 1, write_n 1, address 0 → RD_CAP.
- RD_CAP: chipselect 0, address held 0; sample readdata. bit1 (running)=0 → START. Else bit0 (timeout)=1 → CLEAR. Else reload counter → WAIT.
- CLEAR: write address 0, writedata 0x0000; timeout_seen=1; timeout_count+1 (saturating); reload counter → WAIT.
- hb_flag: set by heartbeat in any state; cleared only in KICK when consumed; heartbeat in the consuming KICK cycle leaves hb_flag=1 (set wins).
- enable deassert: takes effect only at WAIT (→ IDLE next cycle); a bus access sequence in progress (START, KICK..CLEAR) always completes. Watchdog cannot be stopped; disabling simply stops kicking.
- Re-enable from IDLE always goes through START.

## Timing
- All outputs registered; reset values: address 0, chipselect 0, write_n 1, writedata 0, kick_count 0, timeout_count 0, timeout_seen 0, missed_kick 0, busy 0; hb_flag 0; state IDLE.
- Every write is a single cycle with chipselect=1, write_n=0 (slave has no waitrequest).
- Read: request cycle N (RD_ADDR), data captured cycle N+1 (RD_CAP); address must stay 0 in N+1.
- Steady-state kick cycle period: KICK_PERIOD+3 cycles (WAIT, KICK, RD_ADDR, RD_CAP), +1 when CLEAR taken.
- enable rising in IDLE → START write appears on the second edge after enable is sampled (IDLE→START registered, outputs valid in START).
- reset asserted in any state: next edge returns all registers to reset values, aborting any access mid-sequence.

## Test plan
- Reset then idle: enable=0 for 20 cycles → chipselect=0, write_n=1, busy=0, all counters 0.
- Startup (KICK_PERIOD=8, IRQ_EN=1): enable=1 → one write address 1 data 0x0005, then 8 idle WAIT cycles, then KICK.
- Kick with heartbeat: pulse heartbeat during WAIT, model returns readdata 0x0002 → write address 2 data 0, kick_count=1, read address 0, back to WAIT; period KICK_PERIOD+3 cycles.
- Missing heartbeat: no pulse → no address-2 write, missed_kick single pulse, status read still issued, kick_count unchanged; heartbeat coinciding with consuming KICK → next kick also issued.
- Timeout handling: readdata 0x0003 in RD_CAP → write address 0 data 0, timeout_seen=1, timeout_count=1; 256 such events → timeout_count holds 255. readdata 0x0000 → START write re-issued.
- Disable/reset mid-run: enable=0 during KICK → sequence completes to WAIT then IDLE; reset during RD_ADDR → next cycle all outputs at reset values, state IDLE.
